// File: rtl/onehot_decode_sequencer_pkg.sv
// Shared types and widths for the one-hot decode sequencer.
// An entry is {active, code}; inactive entries decode to an all-zero word.
package onehot_decode_sequencer_pkg;

  localparam int unsigned CODE_W   = 4;
  localparam int unsigned ONEHOT_W = 16;
  localparam int unsigned ENTRY_W  = CODE_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  typedef struct packed {
    logic              active;
    logic [CODE_W-1:0] code;
  } entry_t;

  function automatic logic [ONEHOT_W-1:0] decode_entry(input entry_t e);
    logic [ONEHOT_W-1:0] r;
    r = '0;
    if (e.active) r[e.code] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/onehot_decode_sequencer_fifo.sv
// Show-ahead synchronous FIFO buffering decoder entries; full/empty come from count.
// Push while full and pop while empty are ignored.
module decoder_fifo #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/onehot_decode_sequencer.sv
// Replays buffered {active, code} words as registered one-hot strobes,
// each held HOLD_CYCLES and followed by GAP_CYCLES of idle output.
module onehot_decode_sequencer
  import onehot_decode_sequencer_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CODE_W-1:0]             in_code,
  input  logic                          in_active,
  output logic [ONEHOT_W-1:0]           y,
  output logic                          y_valid,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_HG > 2) ? MAX_HG : 2;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);

  state_e               state_q, state_d;
  logic [ONEHOT_W-1:0]  y_q, y_d;
  logic                 yv_q, yv_d;
  logic [CNT_W-1:0]     hold_q, hold_d;
  logic [CNT_W-1:0]     gap_q, gap_d;
  logic                 pop, load;
  logic                 fifo_full, fifo_empty;
  entry_t               wr_entry, head;

  assign wr_entry = '{active: in_active, code: in_code};

  decoder_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (in_valid),
    .pop     (pop),
    .wdata   (wr_entry),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign in_ready = !fifo_full;
  assign y        = y_q;
  assign y_valid  = yv_q;
  assign busy     = (state_q != S_IDLE) || !fifo_empty;

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    yv_d    = yv_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      S_IDLE: load = !fifo_empty;
      S_HOLD: begin
        if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else if (GAP_CYCLES != 0) begin
          state_d = S_GAP;
          y_d     = '0;
          yv_d    = 1'b0;
          gap_d   = GAP_LOAD;
        end else if (!fifo_empty) begin
          load = 1'b1;
        end else begin
          state_d = S_IDLE;
          y_d     = '0;
          yv_d    = 1'b0;
        end
      end
      S_GAP: begin
        if (gap_q != '0)      gap_d   = gap_q - 1'b1;
        else if (!fifo_empty) load    = 1'b1;
        else                  state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Every path that starts a new entry funnels through here.
    if (load) begin
      pop     = 1'b1;
      state_d = S_HOLD;
      y_d     = decode_entry(head);
      yv_d    = 1'b1;
      hold_d  = HOLD_LOAD;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      y_q     <= '0;
      yv_q    <= 1'b0;
      hold_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
    end
  end

endmodule

// File: tb/tb_onehot_decode_sequencer.sv
// Directed bench: default instance (HOLD=4, GAP=1) plus a back-to-back
// instance (HOLD=1, GAP=0), checked against hand-computed vectors.
module tb_onehot_decode_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, in_active, y_valid, busy;
  logic [3:0]  in_code;
  logic [15:0] y;
  logic [2:0]  fifo_count;

  logic        f_valid, f_ready, f_active, f_y_valid, f_busy;
  logic [3:0]  f_code;
  logic [15:0] f_y;
  logic [2:0]  f_count;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  onehot_decode_sequencer u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .in_active  (in_active),
    .y          (y),
    .y_valid    (y_valid),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  onehot_decode_sequencer #(
    .HOLD_CYCLES (1),
    .GAP_CYCLES  (0),
    .FIFO_DEPTH  (4)
  ) u_fast (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (f_valid),
    .in_ready   (f_ready),
    .in_code    (f_code),
    .in_active  (f_active),
    .y          (f_y),
    .y_valid    (f_y_valid),
    .busy       (f_busy),
    .fifo_count (f_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic a);
    in_valid  = v;
    in_code   = c;
    in_active = a;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [3:0]  bb_code [3];
  logic [15:0] bb_y    [16];
  logic [15:0] nl_y    [11];
  logic        nl_v    [11];
  logic [15:0] fs_y    [4];
  logic [3:0]  q [$];
  logic [3:0]  bp_code;
  logic [15:0] exp_bp;
  logic        acc, yv_prev;
  int          accepted, shown, peak;

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 4'h0, 1'b0);
    f_valid = 1'b0; f_code = '0; f_active = 1'b0;
    tick();
    tick();
    chk("rst_y", y, 16'h0);
    chk("rst_yv", y_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", fifo_count, 3'd0);
    reset_n = 1'b1;
    tick();
    chk("rst_ready", in_ready, 1'b1);

    // Single entry; in_code is X whenever in_valid is low.
    drive(1'b1, 4'hA, 1'b1);
    tick();
    drive(1'b0, 4'hx, 1'bx);
    chk("single_count", fifo_count, 3'd1);
    chk("single_busy", busy, 1'b1);
    chk("single_lat_y", y, 16'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("single_y", y, 16'h0400);
      chk("single_yv", y_valid, 1'b1);
      tick();
    end
    chk("single_gap_y", y, 16'h0);
    chk("single_gap_yv", y_valid, 1'b0);
    chk("single_gap_busy", busy, 1'b1);
    tick();
    chk("single_idle_busy", busy, 1'b0);
    chk("single_idle_y", y, 16'h0);

    // Asynchronous reset in the middle of a hold.
    drive(1'b1, 4'hA, 1'b1);
    tick();
    drive(1'b1, 4'h5, 1'b1);
    tick();
    drive(1'b0, 4'hx, 1'bx);
    chk("mid_pre_y", y, 16'h0400);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_y", y, 16'h0);
    chk("mid_rst_yv", y_valid, 1'b0);
    chk("mid_rst_count", fifo_count, 3'd0);
    chk("mid_rst_busy", busy, 1'b0);
    #2;
    reset_n = 1'b1;
    #1;
    chk("mid_rel_ready", in_ready, 1'b1);
    tick();
    chk("mid_after_y", y, 16'h0);

    // Back-to-back pushes of 3, F, 0.
    bb_code = '{4'h3, 4'hF, 4'h0};
    bb_y = '{16'h0008, 16'h0008, 16'h0008, 16'h0008, 16'h0000,
             16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0000,
             16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h0000};
    for (int k = 0; k < 17; k++) begin
      if (k < 3) drive(1'b1, bb_code[k], 1'b1);
      else       drive(1'b0, 4'hx, 1'bx);
      tick();
      if (k >= 1) begin
        chk("bb_y", y, bb_y[k-1]);
        chk("bb_yv", y_valid, bb_y[k-1] != 16'h0);
      end
    end
    chk("bb_idle_busy", busy, 1'b0);

    // Null entry (code 7, inactive) followed by code 5.
    nl_y = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
             16'h0020, 16'h0020, 16'h0020, 16'h0020, 16'h0, 16'h0};
    nl_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 12; k++) begin
      if (k == 0)      drive(1'b1, 4'h7, 1'b0);
      else if (k == 1) drive(1'b1, 4'h5, 1'b1);
      else             drive(1'b0, 4'hx, 1'bx);
      tick();
      if (k >= 1) begin
        chk("null_y", y, nl_y[k-1]);
        chk("null_yv", y_valid, nl_v[k-1]);
      end
    end
    chk("null_idle_busy", busy, 1'b0);

    // Backpressure: in_valid held high with incrementing codes.
    bp_code  = 4'h0;
    accepted = 0;
    shown    = 0;
    peak     = 0;
    yv_prev  = y_valid;
    for (int cyc = 0; cyc < 90; cyc++) begin
      if (accepted < 10) drive(1'b1, bp_code, 1'b1);
      else               drive(1'b0, 4'hx, 1'bx);
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        q.push_back(bp_code);
        bp_code++;
        accepted++;
      end
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      if (fifo_count == 3'd4) chk("bp_full_ready", in_ready, 1'b0);
      if (y_valid && !yv_prev) begin
        if (q.size() != 0) exp_bp = 16'h1 << q.pop_front();
        else               exp_bp = 'x;
        chk("bp_order", y, exp_bp);
        shown++;
      end
      chk("bp_onehot0", $onehot0(y), 1'b1);
      yv_prev = y_valid;
    end
    chk("bp_accepted", accepted, 10);
    chk("bp_shown", shown, 10);
    chk("bp_peak", peak, 4);
    chk("bp_leftover", q.size(), 0);
    chk("bp_idle_busy", busy, 1'b0);

    // HOLD=1, GAP=0: codes 1, 2, 3 appear on consecutive cycles.
    fs_y = '{16'h0002, 16'h0004, 16'h0008, 16'h0000};
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin
        f_valid = 1'b1; f_code = 4'(k + 1); f_active = 1'b1;
      end else begin
        f_valid = 1'b0; f_code = 4'hx; f_active = 1'bx;
      end
      tick();
      if (k == 0) chk("fast_count_push", f_count, 3'd1);
      if (k == 1) chk("fast_count_pushpop", f_count, 3'd1);
      if (k >= 1) begin
        chk("fast_y", f_y, fs_y[k-1]);
        chk("fast_yv", f_y_valid, k < 4);
      end
    end
    chk("fast_idle_busy", f_busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
